// File: rtl/barrel_shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROL/ROR barrel shifter, one log2 step per register stage; latency AMT_W cycles.
// Backpressure: one global advance (out_ready | ~out_valid) stalls every stage together; in_ready follows it.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_badmode
);

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_LSL: r = d << s;
            MODE_LSR: r = d >> s;
            MODE_ASR: r = $signed(d) >>> s;
            MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
            MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] data_q   [AMT_W];
    logic [AMT_W-1:0] amt_q    [AMT_W];
    logic [2:0]       mode_q   [AMT_W];
    logic [AMT_W-1:0] vld_q;

    logic [WIDTH-1:0] src_data [AMT_W];
    logic [AMT_W-1:0] src_amt  [AMT_W];
    logic [2:0]       src_mode [AMT_W];
    logic [AMT_W-1:0] src_vld;
    logic [WIDTH-1:0] nxt_data [AMT_W];
    logic             adv;

    always_comb begin
        adv      = out_ready | ~vld_q[AMT_W-1];
        in_ready = reset_n & adv;

        src_data[0] = in_data;
        src_amt[0]  = in_amt;
        src_mode[0] = in_mode;
        src_vld[0]  = in_valid & in_ready;
        for (int k = 1; k < AMT_W; k++) begin
            src_data[k] = data_q[k-1];
            src_amt[k]  = amt_q[k-1];
            src_mode[k] = mode_q[k-1];
            src_vld[k]  = vld_q[k-1];
        end

        // amt is carried pre-shifted, so bit 0 is always this stage's 2^k select.
        for (int k = 0; k < AMT_W; k++) begin
            nxt_data[k] = src_amt[k][0] ? shift_step(src_data[k], src_mode[k], 1 << k)
                                        : src_data[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= src_vld;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= nxt_data[k];
                amt_q[k]  <= src_amt[k] >> 1;
                mode_q[k] <= src_mode[k];
            end
        end
    end

    assign out_valid   = vld_q[AMT_W-1];
    assign out_data    = data_q[AMT_W-1];
    assign out_zero    = (data_q[AMT_W-1] == '0);
    assign out_badmode = (mode_q[AMT_W-1] > MODE_ROR);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: 8-bit directed vectors plus a 32-bit model-checked sweep.
module tb_barrel_shifter_pipe;

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        b;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_bad8;
    logic [7:0]  in_data8, out_data8;
    logic [2:0]  in_amt8, in_mode8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32, out_bad32;
    logic [31:0] in_data32, out_data32;
    logic [4:0]  in_amt32;
    logic [2:0]  in_mode32;
    bit          rnd32 = 1'b0;

    exp_t sb8[$];
    exp_t sb32[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_amt(in_amt8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_zero(out_zero8), .out_badmode(out_bad8)
    );

    barrel_shifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
        .in_amt(in_amt32), .in_mode(in_mode32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
        .out_zero(out_zero32), .out_badmode(out_bad32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent full-amount reference: rotates and ASR done one bit at a time.
    function automatic logic [31:0] ref32(input logic [31:0] d, input int a, input logic [2:0] m);
        logic [31:0] r;
        r = d;
        case (m)
            3'd0: r = d << a;
            3'd1: r = d >> a;
            3'd2: for (int j = 0; j < a; j++) r = {r[31], r[31:1]};
            3'd3: for (int j = 0; j < a; j++) r = {r[30:0], r[31]};
            3'd4: for (int j = 0; j < a; j++) r = {r[0], r[31:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Called right at a negedge; returns at the negedge following acceptance.
    task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                         input logic [7:0] ed, input logic eb, input bit lat);
        int guard;
        exp_t e;
        guard = 0;
        in_valid8 = 1'b1;
        in_data8  = d;
        in_amt8   = a;
        in_mode8  = m;
        #1;
        while (!in_ready8 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready8) begin
            check("accept8_timeout", 64'd0, 64'd1);
        end else begin
            e.d = {24'd0, ed}; e.z = (ed == 8'd0); e.b = eb; e.acc = cyc; e.lat = lat;
            sb8.push_back(e);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        in_data8  = 8'h5A;
        in_amt8   = 3'd7;
        in_mode8  = 3'd3;
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m);
        int guard;
        exp_t e;
        guard = 0;
        in_valid32 = 1'b1;
        in_data32  = d;
        in_amt32   = a;
        in_mode32  = m;
        #1;
        while (!in_ready32 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready32) begin
            check("accept32_timeout", 64'd0, 64'd1);
        end else begin
            e.d = ref32(d, int'(a), m); e.z = (e.d == 32'd0); e.b = (m > 3'd4);
            e.acc = cyc; e.lat = 1'b0;
            sb32.push_back(e);
        end
        @(negedge clk);
        in_valid32 = 1'b0;
        in_data32  = $urandom;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset_n && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                check("unexpected_out8", {56'd0, out_data8}, 64'hDEAD);
            end else begin
                e = sb8.pop_front();
                check("data8", {56'd0, out_data8}, {32'd0, e.d});
                check("zero8", {63'd0, out_zero8}, {63'd0, e.z});
                check("badmode8", {63'd0, out_bad8}, {63'd0, e.b});
                if (e.lat) check("latency8", 64'(cyc - e.acc), 64'd3);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset_n && out_valid32 && out_ready32) begin
            if (sb32.size() == 0) begin
                check("unexpected_out32", {32'd0, out_data32}, 64'hDEAD);
            end else begin
                e = sb32.pop_front();
                check("data32", {32'd0, out_data32}, {32'd0, e.d});
                check("zero32", {63'd0, out_zero32}, {63'd0, e.z});
                check("badmode32", {63'd0, out_bad32}, {63'd0, e.b});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            out_ready32 = rnd32 ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drain8();
        int guard;
        guard = 0;
        while (sb8.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain8_left", 64'(sb8.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] lsl_tab [8];
        logic [7:0] ror_tab [8];
        logic [7:0] held;
        int guard;

        lsl_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        ror_tab = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

        reset_n    = 1'b0;
        in_valid8  = 1'b0; in_data8 = 8'h00; in_amt8 = 3'd0; in_mode8 = 3'd0;
        out_ready8 = 1'b1;
        in_valid32 = 1'b0; in_data32 = 32'd0; in_amt32 = 5'd0; in_mode32 = 3'd0;
        #1;
        check("rst_out_valid", {63'd0, out_valid8}, 64'd0);
        check("rst_out_data", {56'd0, out_data8}, 64'd0);
        check("rst_out_zero", {63'd0, out_zero8}, 64'd1);
        check("rst_out_badmode", {63'd0, out_bad8}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready8}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Five modes on one operand, amt=3, back to back.
        send8(8'b11010111, 3'd3, 3'd0, 8'b10111000, 1'b0, 1'b1);
        send8(8'b11010111, 3'd3, 3'd1, 8'b00011010, 1'b0, 1'b1);
        send8(8'b11010111, 3'd3, 3'd2, 8'b11111010, 1'b0, 1'b1);
        send8(8'b11010111, 3'd3, 3'd3, 8'b10111110, 1'b0, 1'b1);
        send8(8'b11010111, 3'd3, 3'd4, 8'b11111010, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) send8(8'h01, 3'(i), 3'd0, lsl_tab[i], 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send8(8'h01, 3'(i), 3'd4, ror_tab[i], 1'b0, 1'b1);
        drain8();

        // Stall mid-stream for four cycles.
        fork
            begin
                send8(8'h11, 3'd1, 3'd0, 8'h22, 1'b0, 1'b0);
                send8(8'h22, 3'd1, 3'd0, 8'h44, 1'b0, 1'b0);
                send8(8'h33, 3'd1, 3'd0, 8'h66, 1'b0, 1'b0);
                send8(8'h44, 3'd1, 3'd0, 8'h88, 1'b0, 1'b0);
                send8(8'h55, 3'd1, 3'd0, 8'hAA, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready8 = 1'b0;
                #1;
                held = out_data8;
                check("stall_out_valid", {63'd0, out_valid8}, 64'd1);
                check("stall_head_data", {56'd0, held}, 64'h44);
                for (int j = 0; j < 4; j++) begin
                    if (j > 0) begin
                        @(negedge clk);
                        #1;
                        check("stall_data_held", {56'd0, out_data8}, {56'd0, held});
                    end
                    check("stall_in_ready", {63'd0, in_ready8}, 64'd0);
                end
                @(negedge clk);
                out_ready8 = 1'b1;
            end
        join
        drain8();

        send8(8'b11110011, 3'd5, 3'd6, 8'b11110011, 1'b1, 1'b1);
        send8(8'h80, 3'd1, 3'd0, 8'h00, 1'b0, 1'b1);
        drain8();

        // Reset with three beats in flight: none may ever emerge.
        send8(8'h0F, 3'd1, 3'd0, 8'h1E, 1'b0, 1'b0);
        send8(8'h0F, 3'd2, 3'd0, 8'h3C, 1'b0, 1'b0);
        send8(8'h0F, 3'd3, 3'd0, 8'h78, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid8}, 64'd0);
        check("midrst_out_data", {56'd0, out_data8}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready8}, 64'd0);
        sb8.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("postrst_in_ready", {63'd0, in_ready8}, 64'd1);
        repeat (6) @(negedge clk);
        send8(8'h0F, 3'd4, 3'd3, 8'hF0, 1'b0, 1'b1);
        drain8();

        // 32-bit sweep: every mode x every amount, random idles and random out_ready.
        rnd32 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_data32 = $urandom;
                @(negedge clk);
            end
            send32($urandom, 5'(i / 8), 3'(i % 8));
        end
        send32(32'h8000_0001, 5'd31, 3'd0);
        send32(32'h8000_0000, 5'd31, 3'd2);
        guard = 0;
        while (sb32.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain32_left", 64'(sb32.size()), 64'd0);
        rnd32 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
